// File: rtl/sd_spi_port.sv
// SD-card SPI port (mode 0) in the 8086 drive I/O window: DATA, CTRL/STATUS and DIV registers.
// Define SD_DRIVE_IRQ_EN to add the IRQ output that fires when a transfer completes.
module sd_spi_port #(
  parameter logic [7:0]  DIV_RESET   = 8'd99,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic [1:0] A,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOUT_EN,
  output logic       SD_SCK,
  output logic       SD_MOSI,
  input  logic       SD_MISO,
  output logic       SD_CS_N
`ifdef SD_DRIVE_IRQ_EN
  ,
  output logic       IRQ
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t                       state;
  logic [SYNC_STAGES-1:0][2:0]  sync_q;
  logic [2:0]                   sync_prev;
  logic [2:0]                   strobe_raw;
  logic [2:0]                   strobe_rise;
  logic                         wr_data, wr_ctrl, wr_div;
  logic                         rd_status, rd_data;
  logic [7:0]                   shift, rxdata, div, cnt;
  logic [2:0]                   bitcnt;
  logic                         busy, ovr, irqen, miso_q;

  // Bus strobes are asynchronous to CLK: {write, status read, data read}.
  assign strobe_raw  = {CS & ~WR, CS & ~RD & (A == 2'd1), CS & ~RD & (A == 2'd0)};
  assign strobe_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

  assign wr_data   = strobe_rise[2] & (A == 2'd0);
  assign wr_ctrl   = strobe_rise[2] & (A == 2'd1);
  assign wr_div    = strobe_rise[2] & (A == 2'd2);
  assign rd_status = strobe_rise[1];
  assign rd_data   = strobe_rise[0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q    <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= strobe_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      shift   <= '1;
      rxdata  <= 8'hFF;
      div     <= DIV_RESET;
      cnt     <= '0;
      bitcnt  <= '0;
      busy    <= 1'b0;
      ovr     <= 1'b0;
      irqen   <= 1'b0;
      miso_q  <= 1'b0;
      SD_SCK  <= 1'b0;
      SD_MOSI <= 1'b1;
      SD_CS_N <= 1'b1;
`ifdef SD_DRIVE_IRQ_EN
      IRQ     <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        SD_CS_N <= DIN[0];
        irqen   <= DIN[2];
      end
      if (wr_div) div <= DIN;
      // Later assignment wins: an overrun in the same cycle as a STATUS read stays set.
      if (rd_status) ovr <= 1'b0;
      if (wr_data && busy) ovr <= 1'b1;

      unique case (state)
        S_IDLE: begin
          // BUSY is raised on capture; the next cycle presents bit 7 and starts the clock.
          if (busy) begin
            SD_MOSI <= shift[7];
            cnt     <= div;
            bitcnt  <= '0;
            state   <= S_LO;
          end else if (wr_data) begin
            shift <= DIN;
            busy  <= 1'b1;
          end
        end
        S_LO: begin
          if (cnt == 8'd0) begin
            SD_SCK <= 1'b1;
            miso_q <= SD_MISO;
            cnt    <= div;
            state  <= S_HI;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HI: begin
          if (cnt == 8'd0) begin
            SD_SCK  <= 1'b0;
            shift   <= {shift[6:0], miso_q};
            SD_MOSI <= (bitcnt == 3'd7) ? 1'b1 : shift[6];
            cnt     <= div;
            bitcnt  <= bitcnt + 3'd1;
            state   <= (bitcnt == 3'd7) ? S_DONE : S_LO;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DONE: begin
          rxdata  <= shift;
          busy    <= 1'b0;
          SD_MOSI <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

`ifdef SD_DRIVE_IRQ_EN
      if (rd_data || (wr_ctrl && !DIN[2])) IRQ <= 1'b0;
      if (state == S_DONE && irqen) IRQ <= 1'b1;
`endif
    end
  end

  always_comb begin
    DOUT = '0;
    unique case (A)
      2'd0:    DOUT = rxdata;
      2'd1:    DOUT = {4'b0000, ovr, irqen, busy, SD_CS_N};
      2'd2:    DOUT = div;
      default: DOUT = '0;
    endcase
  end

  assign DOUT_EN = CS & ~RD;

endmodule
